// File: rtl/uart_pkg.sv
// Shared UART types and default widths for the transmit and receive paths.
package uart_pkg;

   localparam int UART_DATA_WIDTH = 8;
   localparam int UART_DIV_WIDTH  = 16;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

   typedef enum logic [1:0] {NONE, EVEN, ODD} parity_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable bit-period down-counter: o_bit_tick marks the last cycle of each bit period.
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int DivWidth = UART_DIV_WIDTH
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_load,
   input  logic [DivWidth-1:0] i_div,
   output logic                o_bit_tick
);

   logic [DivWidth-1:0] div_q;
   logic [DivWidth-1:0] cnt_q;

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         div_q <= '0;
         cnt_q <= '0;
      end else if (i_load) begin
         div_q <= i_div;
         cnt_q <= i_div;
      end else if (cnt_q == '0) begin
         cnt_q <= div_q;
      end else begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign o_bit_tick = (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops one FIFO word per frame and serialises start, data, parity and stop bits.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DataWidth = UART_DATA_WIDTH,
   parameter int DivWidth  = UART_DIV_WIDTH,
   parameter int ParityEn  = 0,
   parameter int ParityOdd = 0,
   parameter int StopBits  = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_en,
   input  logic [DivWidth-1:0]  i_baud_div,
   input  logic [DataWidth-1:0] i_fifo_data,
   input  logic                 i_fifo_empty,
   output logic                 o_fifo_rd_en,
   output logic                 o_tx,
   output logic                 o_busy,
   output logic                 o_done
);

   localparam int                  IdxWidth  = (DataWidth > 1) ? $clog2(DataWidth) : 1;
   localparam logic [IdxWidth-1:0] LAST_BIT  = IdxWidth'(DataWidth - 1);
   localparam logic                LAST_STOP = (StopBits == 2);
   localparam parity_e             PAR_MODE  = (ParityEn == 0) ? NONE :
                                               ((ParityOdd != 0) ? ODD : EVEN);

   tx_state_e            state_q, state_d;
   logic [DataWidth-1:0] shift_q, shift_d;
   logic [IdxWidth-1:0]  bit_idx_q, bit_idx_d;
   logic                 stop_idx_q, stop_idx_d;
   logic                 parity_q, parity_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 bit_tick;
   logic                 last_stop;
   logic                 pop;

   uart_baud_cnt #(.DivWidth(DivWidth)) u_baud_cnt (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (pop),
      .i_div      (i_baud_div),
      .o_bit_tick (bit_tick)
   );

   assign last_stop = (state_q == STOP) && bit_tick && (stop_idx_q == LAST_STOP);
   // A pop either leaves IDLE or chains the next frame off the final stop-bit cycle.
   assign pop = !i_rst && i_en && !i_fifo_empty && ((state_q == IDLE) || last_stop);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         parity_q   <= 1'b0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         parity_q   <= parity_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
      end
   end

   // NOTE: every signal gets a default first so no path through the block infers a latch.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      parity_d   = parity_q;
      case (state_q)
         START:  if (bit_tick) state_d = DATA;
         DATA: begin
            if (bit_tick) begin
               parity_d = parity_q ^ shift_q[0];
               shift_d  = shift_q >> 1;
               if (bit_idx_q == LAST_BIT) begin
                  bit_idx_d = '0;
                  state_d   = (PAR_MODE == NONE) ? STOP : PARITY;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end
         end
         PARITY: if (bit_tick) state_d = STOP;
         STOP: begin
            if (last_stop) begin
               state_d    = IDLE;
               stop_idx_d = 1'b0;
            end else if (bit_tick) begin
               stop_idx_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (pop) begin
         state_d    = START;
         shift_d    = i_fifo_data;
         parity_d   = (PAR_MODE == ODD);
         bit_idx_d  = '0;
         stop_idx_d = 1'b0;
      end
   end

   // The line level is computed from next-state values so the registered pin lines up with the state.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         PARITY:  tx_d = parity_d;
         default: tx_d = 1'b1;
      endcase
      busy_d       = (state_d != IDLE);
      o_fifo_rd_en = pop;
      o_done       = last_stop && !i_rst;
   end

   assign o_tx   = tx_q;
   assign o_busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, per-DUT monitors check the line.
module tb_uart_tx;

   typedef struct {
      logic [15:0] bits;
      int          nbits;
      int          cpb;
   } frame_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b0;
   logic [15:0] div = 16'd3;

   logic       empty0, empty1, rd0, rd1, tx0, tx1, busy0, busy1, done0, done1;
   logic [7:0] fdata0, fdata1;
   logic [7:0] mem0 [0:63];
   logic [7:0] mem1 [0:63];
   int         wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;
   logic       pend0 = 1'b0, pend1 = 1'b0;

   frame_t exp0[$];
   frame_t exp1[$];
   bit     mon_act [2];
   int     n_checks = 0;
   int     n_errors = 0;

   always #5 clk = ~clk;

   uart_tx dut0 (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_baud_div(div),
      .i_fifo_data(fdata0), .i_fifo_empty(empty0), .o_fifo_rd_en(rd0),
      .o_tx(tx0), .o_busy(busy0), .o_done(done0)
   );

   uart_tx #(.ParityEn(1), .ParityOdd(1), .StopBits(2)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_baud_div(div),
      .i_fifo_data(fdata1), .i_fifo_empty(empty1), .o_fifo_rd_en(rd1),
      .o_tx(tx1), .o_busy(busy1), .o_done(done1)
   );

   // FIFO models: a pop seen during a cycle advances the read pointer just after the edge.
   assign empty0 = (wp0 == rp0);
   assign empty1 = (wp1 == rp1);
   assign fdata0 = mem0[rp0[5:0]];
   assign fdata1 = mem1[rp1[5:0]];

   always @(negedge clk) begin
      pend0 = rd0;
      pend1 = rd1;
      if (rd0 && empty0) check("dut0_rd_while_empty", 1, 0);
      if (rd1 && empty1) check("dut1_rd_while_empty", 1, 0);
   end

   always @(posedge clk) begin
      #1;
      if (pend0) rp0++;
      if (pend1) rp1++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic int exp_size(input int w);
      return (w == 0) ? exp0.size() : exp1.size();
   endfunction

   function automatic frame_t exp_pop(input int w);
      if (w == 0) return exp0.pop_front();
      return exp1.pop_front();
   endfunction

   function automatic logic tx_of(input int w);   return (w == 0) ? tx0 : tx1;     endfunction
   function automatic logic busy_of(input int w); return (w == 0) ? busy0 : busy1; endfunction
   function automatic logic done_of(input int w); return (w == 0) ? done0 : done1; endfunction
   function automatic logic rd_of(input int w);   return (w == 0) ? rd0 : rd1;     endfunction

   task automatic push_exp(input int w, input logic [15:0] bits, input int nbits, input int cpb);
      frame_t f;
      f.bits  = bits;
      f.nbits = nbits;
      f.cpb   = cpb;
      if (w == 0) exp0.push_back(f);
      else        exp1.push_back(f);
   endtask

   task automatic push_fifo(input int w, input logic [7:0] b);
      if (w == 0) begin
         mem0[wp0[5:0]] = b;
         wp0++;
      end else begin
         mem1[wp1[5:0]] = b;
         wp1++;
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic bit pending();
      return (exp0.size() != 0) || (exp1.size() != 0) || mon_act[0] || mon_act[1];
   endfunction

   task automatic wait_idle(input int budget);
      int n = 0;
      while (pending() && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain_in_budget", pending(), 0);
   endtask

   // Monitor: on each pop, take the next expected frame and check every bit period cycle by cycle.
   task automatic monitor(input int w);
      frame_t f;
      bit     chained = 0;
      bit     aborted, last;
      int     match, busy_cnt, done_cnt, done_last, rd_mid;
      int     fnum = 0;
      forever begin
         if (!chained) begin
            @(negedge clk);
            if (rst || rd_of(w) !== 1'b1) continue;
            if (exp_size(w) == 0) begin
               check($sformatf("dut%0d_unexpected_pop", w), 1, 0);
               continue;
            end
         end
         chained   = 0;
         f         = exp_pop(w);
         mon_act[w] = 1;
         fnum++;
         aborted   = 0;
         busy_cnt  = 0;
         done_cnt  = 0;
         done_last = 0;
         rd_mid    = 0;
         for (int b = 0; b < f.nbits && !aborted; b++) begin
            match = 0;
            for (int c = 0; c < f.cpb; c++) begin
               @(negedge clk);
               if (rst) begin
                  aborted = 1;
                  break;
               end
               last = (b == f.nbits - 1) && (c == f.cpb - 1);
               if (tx_of(w) === f.bits[b]) match++;
               if (busy_of(w) === 1'b1) busy_cnt++;
               if (done_of(w) === 1'b1) begin
                  done_cnt++;
                  if (last) done_last = 1;
               end
               if (last) begin
                  check($sformatf("dut%0d_f%0d_pop_at_done", w, fnum), rd_of(w), exp_size(w) > 0);
                  chained = (rd_of(w) === 1'b1) && (exp_size(w) > 0);
               end else if (rd_of(w) === 1'b1) begin
                  rd_mid++;
               end
            end
            if (!aborted)
               check($sformatf("dut%0d_f%0d_bit%0d_cycles", w, fnum, b), match, f.cpb);
         end
         if (!aborted) begin
            check($sformatf("dut%0d_f%0d_busy_cycles", w, fnum), busy_cnt, f.nbits * f.cpb);
            check($sformatf("dut%0d_f%0d_done_count", w, fnum), done_cnt, 1);
            check($sformatf("dut%0d_f%0d_done_last", w, fnum), done_last, 1);
            check($sformatf("dut%0d_f%0d_rd_mid_frame", w, fnum), rd_mid, 0);
            if (!chained) begin
               @(negedge clk);
               check($sformatf("dut%0d_f%0d_busy_after", w, fnum), busy_of(w), 0);
               check($sformatf("dut%0d_f%0d_tx_after", w, fnum), tx_of(w), 1);
            end
         end
         mon_act[w] = 0;
      end
   endtask

   initial monitor(0);
   initial monitor(1);

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rd_cnt, low_cnt;

      // Reset values.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tx", tx0, 1);
      check("rst_busy", busy0, 0);
      check("rst_done", done0, 0);
      check("rst_rd_en", rd0, 0);
      check("rst_tx_p", tx1, 1);
      check("rst_busy_p", busy1, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      en  = 1'b1;
      step(2);

      // Single byte 0xA5, 4 cycles per bit.
      push_exp(0, {1'b1, 8'hA5, 1'b0}, 10, 4);
      push_fifo(0, 8'hA5);
      wait_idle(200);

      // Back-to-back 0x00 then 0xFF.
      push_exp(0, {1'b1, 8'h00, 1'b0}, 10, 4);
      push_exp(0, {1'b1, 8'hFF, 1'b0}, 10, 4);
      push_fifo(0, 8'h00);
      push_fifo(0, 8'hFF);
      wait_idle(300);

      // Enable dropped mid-frame: frame completes, queued byte stays in the FIFO.
      push_exp(0, {1'b1, 8'h5A, 1'b0}, 10, 4);
      push_fifo(0, 8'h5A);
      step(12);
      en = 1'b0;
      push_fifo(0, 8'h11);
      wait_idle(200);
      step(20);
      check("en_low_fifo_level", wp0 - rp0, 1);

      // Divisor 3 -> 0 mid-frame: first frame stays at 4 cycles/bit, next at 1.
      push_exp(0, {1'b1, 8'h11, 1'b0}, 10, 4);
      push_exp(0, {1'b1, 8'h3C, 1'b0}, 10, 1);
      push_fifo(0, 8'h3C);
      en = 1'b1;
      step(8);
      div = 16'd0;
      wait_idle(200);
      div = 16'd3;
      step(2);

      // Empty FIFO with enable: no pops, line idle.
      rd_cnt  = 0;
      low_cnt = 0;
      repeat (30) begin
         @(negedge clk);
         if (rd0 !== 1'b0) rd_cnt++;
         if (tx0 !== 1'b1) low_cnt++;
      end
      check("empty_rd_en_cycles", rd_cnt, 0);
      check("empty_tx_low_cycles", low_cnt, 0);
      step(1);

      // Odd parity, two stop bits, 2 cycles per bit: 0x03 -> parity 1, 0x80 -> parity 0.
      div = 16'd1;
      push_exp(1, {2'b11, 1'b1, 8'h03, 1'b0}, 12, 2);
      push_exp(1, {2'b11, 1'b0, 8'h80, 1'b0}, 12, 2);
      push_fifo(1, 8'h03);
      push_fifo(1, 8'h80);
      wait_idle(200);
      div = 16'd3;
      step(2);

      // Reset mid-frame for 3 cycles.
      push_exp(0, {1'b1, 8'hC3, 1'b0}, 10, 4);
      push_fifo(0, 8'hC3);
      step(10);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrst_tx", tx0, 1);
      check("midrst_busy", busy0, 0);
      check("midrst_rd_en", rd0, 0);
      check("midrst_done", done0, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(5);
      @(negedge clk);
      check("post_rst_fifo_level", wp0 - rp0, 0);
      check("post_rst_tx", tx0, 1);
      check("post_rst_busy", busy0, 0);
      step(1);

      // Recovery after reset.
      push_exp(0, {1'b1, 8'h81, 1'b0}, 10, 4);
      push_fifo(0, 8'h81);
      wait_idle(200);
      step(5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
